// File: rtl/triple_repeat_tx.sv
// Rate-1/3 repetition-code serializer: each data bit goes out LSB-first as three identical beats.
// Optional fault injection on one copy per triplet when TRIPLE_REPEAT_TX_ERR_INJECT_EN is defined.
module triple_repeat_tx #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_data,
`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
  input  logic             err_inj,
  input  logic [1:0]       err_pos,
`endif
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_bit,
  output logic             out_first,
  output logic             out_last
);

  localparam int unsigned IDX_W = $clog2(NBITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);
  localparam logic [1:0] LAST_REP = 2'd2;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [1:0]         rep_cnt_q, rep_cnt_d;
  logic               flip_c;
  logic               last_beat_c;
  logic               accept_c;

`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
  logic               inj_q, inj_d;
  logic [1:0]         pos_q, pos_d;
`endif

  assign last_beat_c = (state_q == SEND) && (bit_idx_q == LAST_IDX) && (rep_cnt_q == LAST_REP);
  // Ready in IDLE, or on a completing last beat so frames run back-to-back.
  assign in_rdy      = !rst && ((state_q == IDLE) || (last_beat_c && out_rdy));
  assign accept_c    = in_val && in_rdy;

`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
  assign flip_c = inj_q && (rep_cnt_q == pos_q);
`else
  assign flip_c = 1'b0;
`endif

  assign out_val   = (state_q == SEND);
  assign out_bit   = (state_q == SEND) && (shreg_q[0] ^ flip_c);
  assign out_first = (state_q == SEND) && (bit_idx_q == '0) && (rep_cnt_q == 2'd0);
  assign out_last  = last_beat_c;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
    inj_d     = inj_q;
    pos_d     = pos_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = SEND;
          shreg_d   = in_data;
          bit_idx_d = '0;
          rep_cnt_d = 2'd0;
`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
          inj_d     = err_inj && (err_pos != 2'd3);
          pos_d     = err_pos;
`endif
        end
      end
      SEND: begin
        if (out_rdy) begin
          if (last_beat_c) begin
            bit_idx_d = '0;
            rep_cnt_d = 2'd0;
            if (accept_c) begin
              shreg_d = in_data;
`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
              inj_d   = err_inj && (err_pos != 2'd3);
              pos_d   = err_pos;
`endif
            end else begin
              state_d = IDLE;
              shreg_d = '0;
`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
              inj_d   = 1'b0;
              pos_d   = 2'd0;
`endif
            end
          end else if (rep_cnt_q == LAST_REP) begin
            rep_cnt_d = 2'd0;
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end else begin
            rep_cnt_d = rep_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      rep_cnt_q <= 2'd0;
`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
      inj_q     <= 1'b0;
      pos_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      rep_cnt_q <= rep_cnt_d;
`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
      inj_q     <= inj_d;
      pos_q     <= pos_d;
`endif
    end
  end

endmodule

// File: tb/tb_triple_repeat_tx.sv
// Directed bench for triple_repeat_tx (NBITS=8): reset, framing, back-to-back, stalls, mid-frame reset.
module tb_triple_repeat_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       out_val;
  logic       out_rdy;
  logic       out_bit;
  logic       out_first;
  logic       out_last;
  logic       err_inj;
  logic [1:0] err_pos;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  triple_repeat_tx #(.NBITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
    .err_inj   (err_inj),
    .err_pos   (err_pos),
`endif
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Send one word and follow nbeats beats against the bench's bit model.
  task automatic run_frame(input logic [7:0] d, input bit stall, input logic inj,
                           input logic [1:0] pos, input int nbeats);
    logic [3:0] pat = 4'b1001;
    logic       beats [0:23];
    logic       pbit, pfirst, plast, pstalled;
    logic       eb, a, b2, c;
    logic [7:0] voted;
    int         b = 0;
    int         cyc = 0;
    in_val  = 1'b1;
    in_data = d;
    err_inj = inj;
    err_pos = pos;
    out_rdy = 1'b0;
    #1;
    check("accept_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk); #1;
    in_val   = 1'b0;
    in_data  = ~d;
    err_inj  = 1'b0;
    err_pos  = 2'd0;
    pstalled = 1'b0;
    pbit = 1'b0; pfirst = 1'b0; plast = 1'b0;
    while (b < nbeats && cyc < 200) begin
      out_rdy = stall ? pat[cyc % 4] : 1'b1;
      #1;
      eb = d[b / 3] ^ (inj && pos != 2'd3 && (b % 3) == int'(pos));
      check("out_val", 32'(out_val), 32'd1);
      check("out_bit", 32'(out_bit), 32'(eb));
      check("out_first", 32'(out_first), 32'(b == 0));
      check("out_last", 32'(out_last), 32'(b == 23));
      check("in_rdy_send", 32'(in_rdy), 32'((b == 23) && out_rdy));
      if (pstalled) begin
        check("stall_bit", 32'(out_bit), 32'(pbit));
        check("stall_first", 32'(out_first), 32'(pfirst));
        check("stall_last", 32'(out_last), 32'(plast));
      end
      pbit = out_bit; pfirst = out_first; plast = out_last;
      pstalled = !out_rdy;
      if (out_rdy) begin
        beats[b] = out_bit;
        b++;
      end
      cyc++;
      if (b < nbeats) begin
        @(posedge clk); #1;
      end
    end
    check("beats", 32'(b), 32'(nbeats));
    @(posedge clk); #1;
    out_rdy = 1'b0;
    if (nbeats == 24 && b == 24) begin
      #1;
      check("end_val", 32'(out_val), 32'd0);
      check("end_rdy", 32'(in_rdy), 32'd1);
      for (int i = 0; i < 8; i++) begin
        a  = beats[3*i];
        b2 = beats[3*i+1];
        c  = beats[3*i+2];
        voted[i] = (a & b2) | (a & c) | (b2 & c);
      end
      check("majority", 32'(voted), 32'(d));
    end
  endtask

  initial begin
    logic [23:0] a5_pat;
    logic        eb;
    a5_pat  = 24'b111_000_111_000_000_111_000_111;
    rst     = 1'b1;
    in_val  = 1'b1;
    in_data = 8'h55;
    out_rdy = 1'b1;
    err_inj = 1'b0;
    err_pos = 2'd0;

    // T1 reset
    @(posedge clk); @(posedge clk); #1;
    check("rst_val", 32'(out_val), 32'd0);
    check("rst_rdy", 32'(in_rdy), 32'd0);
    rst    = 1'b0;
    in_val = 1'b0;
    #1;
    check("post_rst_rdy", 32'(in_rdy), 32'd1);
    check("post_rst_val", 32'(out_val), 32'd0);
    check("post_rst_bit", 32'(out_bit), 32'd0);
    check("post_rst_first", 32'(out_first), 32'd0);
    check("post_rst_last", 32'(out_last), 32'd0);

    // T2 single word, literal beat pattern (beat 0 is the MSB of a5_pat)
    in_val = 1'b1; in_data = 8'hA5; out_rdy = 1'b1;
    #1;
    @(posedge clk); #1;
    in_val = 1'b0;
    for (int k = 0; k < 24; k++) begin
      #1;
      check("t2_val", 32'(out_val), 32'd1);
      check("t2_bit", 32'(out_bit), 32'(a5_pat[23-k]));
      check("t2_first", 32'(out_first), 32'(k == 0));
      check("t2_last", 32'(out_last), 32'(k == 23));
      @(posedge clk); #1;
    end
    #1;
    check("t2_idle", 32'(out_val), 32'd0);

    // T3 back-to-back FF then 00
    in_val = 1'b1; in_data = 8'hFF; out_rdy = 1'b1;
    #1;
    @(posedge clk); #1;
    in_data = 8'h00;
    for (int k = 0; k < 48; k++) begin
      if (k == 24) in_val = 1'b0;
      #1;
      eb = (k < 24);
      check("t3_val", 32'(out_val), 32'd1);
      check("t3_bit", 32'(out_bit), 32'(eb));
      check("t3_first", 32'(out_first), 32'((k % 24) == 0));
      check("t3_last", 32'(out_last), 32'((k % 24) == 23));
      check("t3_rdy", 32'(in_rdy), 32'((k % 24) == 23));
      @(posedge clk); #1;
    end
    #1;
    check("t3_idle", 32'(out_val), 32'd0);

    // T4 backpressure
    run_frame(8'h3C, 1'b1, 1'b0, 2'd0, 24);

    // T5 reset after beat 10
    run_frame(8'h0F, 1'b0, 1'b0, 2'd0, 11);
    rst = 1'b1;
    #1;
    check("t5_rdy_in_rst", 32'(in_rdy), 32'd0);
    @(posedge clk); #1;
    check("t5_val", 32'(out_val), 32'd0);
    check("t5_rdy", 32'(in_rdy), 32'd0);
    check("t5_first", 32'(out_first), 32'd0);
    check("t5_bit", 32'(out_bit), 32'd0);
    rst = 1'b0;
    #1;
    check("t5_rdy_rel", 32'(in_rdy), 32'd1);
    check("t5_val_rel", 32'(out_val), 32'd0);
    run_frame(8'h81, 1'b0, 1'b0, 2'd0, 24);
    run_frame(8'h5A, 1'b1, 1'b0, 2'd0, 24);

`ifdef TRIPLE_REPEAT_TX_ERR_INJECT_EN
    // T6 fault injection on middle, first and no copy
    run_frame(8'hA5, 1'b0, 1'b1, 2'd1, 24);
    run_frame(8'hA5, 1'b1, 1'b1, 2'd0, 24);
    run_frame(8'hC3, 1'b0, 1'b1, 2'd3, 24);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
